// File: rtl/instruction_decode_latch_if.sv
// Fetch/execute-to-decode bundle for the IF/ID pipeline latch.
// The slave side is the latch; the master side is the surrounding pipeline.
interface instruction_decode_latch_if;
  logic [23:0] IF_output;
  logic        branch_flush;
  logic        ex_is_load;
  logic [3:0]  ex_rd;
  logic        data_stall;
  logic        id_valid;
  logic [7:0]  id_pc;
  logic [3:0]  id_opcode;
  logic [3:0]  id_rd;
  logic [3:0]  id_rs1;
  logic [3:0]  id_rs2;
  logic [7:0]  id_imm;
  logic [7:0]  stall_count;
  logic [7:0]  flush_count;

  modport master (
    output IF_output, branch_flush, ex_is_load, ex_rd,
    input  data_stall, id_valid, id_pc, id_opcode, id_rd, id_rs1, id_rs2,
           id_imm, stall_count, flush_count
  );

  modport slave (
    input  IF_output, branch_flush, ex_is_load, ex_rd,
    output data_stall, id_valid, id_pc, id_opcode, id_rd, id_rs1, id_rs2,
           id_imm, stall_count, flush_count
  );
endinterface

// File: rtl/instruction_decode_latch.sv
// IF/ID pipeline latch with load-use hazard stall, branch flush bubble
// and saturating stall/flush event counters.
module instruction_decode_latch #(
  parameter logic [3:0]  LOAD_OPCODE = 4'b1000,
  parameter logic [15:0] NOP_INSTR   = 16'h0000
) (
  input  logic clk,
  input  logic rst_n,
  instruction_decode_latch_if.slave bus
);
  // Opcode field width follows the load-opcode encoding.
  localparam int OPW = $bits(LOAD_OPCODE);

  typedef enum logic {RUN, STALL} state_t;

  state_t      state;
  logic        held_valid;
  logic [7:0]  held_pc;
  logic [15:0] held_instr;
  logic [7:0]  stall_cnt;
  logic [7:0]  flush_cnt;
  logic        hazard;
  logic        stall;

  assign bus.id_pc     = held_pc;
  assign bus.id_opcode = held_instr[15 -: OPW];
  assign bus.id_rd     = held_instr[11:8];
  assign bus.id_rs1    = held_instr[7:4];
  assign bus.id_rs2    = held_instr[3:0];
  assign bus.id_imm    = held_instr[7:0];
  assign bus.stall_count = stall_cnt;
  assign bus.flush_count = flush_cnt;

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign hazard = held_valid & bus.ex_is_load & (bus.ex_rd != 4'd0) &
                  ((bus.ex_rd == held_instr[7:4]) | (bus.ex_rd == held_instr[3:0]));
  assign stall  = hazard & (state == RUN) & ~bus.branch_flush;

  assign bus.data_stall = stall;
  assign bus.id_valid   = held_valid & ~stall & ~bus.branch_flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      held_valid <= 1'b0;
      held_pc    <= 8'h00;
      held_instr <= NOP_INSTR;
      stall_cnt  <= 8'h00;
      flush_cnt  <= 8'h00;
    end else if (bus.branch_flush) begin
      state      <= RUN;
      held_valid <= 1'b0;
      held_pc    <= 8'h00;
      held_instr <= NOP_INSTR;
      if (flush_cnt != 8'hFF) flush_cnt <= flush_cnt + 8'd1;
    end else if (stall) begin
      state <= STALL;
      if (stall_cnt != 8'hFF) stall_cnt <= stall_cnt + 8'd1;
    end else begin
      // STALL always releases after one cycle, so back-to-back hazards still progress.
      state      <= RUN;
      held_valid <= 1'b1;
      held_pc    <= bus.IF_output[7:0];
      held_instr <= bus.IF_output[23:8];
    end
  end
endmodule

// File: tb/tb_instruction_decode_latch.sv
// Directed self-checking bench for instruction_decode_latch.
module tb_instruction_decode_latch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  instruction_decode_latch_if bus ();

  instruction_decode_latch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.branch_flush = 1'b0;
    bus.ex_is_load = 1'b0;
    bus.ex_rd = 4'd0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic capture(input logic [15:0] instr, input logic [7:0] pc);
    bus.IF_output = {instr, pc};
    tick();
  endtask

  task automatic test_reset();
    bus.IF_output = {16'hABCD, 8'h77};
    bus.branch_flush = 1'b0;
    bus.ex_is_load = 1'b0;
    bus.ex_rd = 4'd0;
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.id_valid !== 1'b0 || bus.data_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: id_valid=%b data_stall=%b, required 0 0", bus.id_valid, bus.data_stall);
    end
    checks++;
    if ({bus.id_pc, bus.id_opcode, bus.id_rd, bus.id_rs1, bus.id_rs2, bus.id_imm} !== 32'h0) begin
      errors++;
      $display("FAIL reset_fields: pc=%h op=%h rd=%h rs1=%h rs2=%h imm=%h, required all 0",
               bus.id_pc, bus.id_opcode, bus.id_rd, bus.id_rs1, bus.id_rs2, bus.id_imm);
    end
    checks++;
    if (bus.stall_count !== 8'h00 || bus.flush_count !== 8'h00) begin
      errors++;
      $display("FAIL reset_counts: stall=%h flush=%h, required 00 00", bus.stall_count, bus.flush_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_capture();
    do_reset();
    capture(16'h5012, 8'h00);
    checks++;
    if (bus.id_valid !== 1'b1 || bus.id_pc !== 8'h00 || bus.id_opcode !== 4'h5 ||
        bus.id_rd !== 4'h0 || bus.id_rs1 !== 4'h1 || bus.id_rs2 !== 4'h2 || bus.id_imm !== 8'h12) begin
      errors++;
      $display("FAIL capture_first: v=%b pc=%h op=%h rd=%h rs1=%h rs2=%h imm=%h, required 1 00 5 0 1 2 12",
               bus.id_valid, bus.id_pc, bus.id_opcode, bus.id_rd, bus.id_rs1, bus.id_rs2, bus.id_imm);
    end
    capture(16'hC9AB, 8'h3E);
    checks++;
    if (bus.id_pc !== 8'h3E || bus.id_opcode !== 4'hC || bus.id_rd !== 4'h9 || bus.id_imm !== 8'hAB) begin
      errors++;
      $display("FAIL capture_second: pc=%h op=%h rd=%h imm=%h, required 3e c 9 ab",
               bus.id_pc, bus.id_opcode, bus.id_rd, bus.id_imm);
    end
  endtask

  task automatic test_stall();
    do_reset();
    capture(16'h5312, 8'h04);
    bus.ex_is_load = 1'b1;
    bus.ex_rd = 4'd1;
    bus.IF_output = {16'h6045, 8'h05};
    #1;
    checks++;
    if (bus.data_stall !== 1'b1 || bus.id_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_assert: data_stall=%b id_valid=%b, required 1 0", bus.data_stall, bus.id_valid);
    end
    tick();
    checks++;
    if (bus.data_stall !== 1'b0 || bus.id_pc !== 8'h04 || bus.id_opcode !== 4'h5 ||
        bus.id_rd !== 4'h3 || bus.stall_count !== 8'd1) begin
      errors++;
      $display("FAIL stall_hold: stall=%b pc=%h op=%h rd=%h cnt=%0d, required 0 04 5 3 1",
               bus.data_stall, bus.id_pc, bus.id_opcode, bus.id_rd, bus.stall_count);
    end
    tick();
    checks++;
    if (bus.id_pc !== 8'h05 || bus.id_opcode !== 4'h6 || bus.id_valid !== 1'b1 ||
        bus.data_stall !== 1'b0 || bus.stall_count !== 8'd1) begin
      errors++;
      $display("FAIL stall_release: pc=%h op=%h v=%b stall=%b cnt=%0d, required 05 6 1 0 1",
               bus.id_pc, bus.id_opcode, bus.id_valid, bus.data_stall, bus.stall_count);
    end
    bus.ex_is_load = 1'b0;
  endtask

  task automatic test_rd_zero();
    do_reset();
    capture(16'h5002, 8'h06);
    bus.ex_is_load = 1'b1;
    bus.ex_rd = 4'd0;
    #1;
    checks++;
    if (bus.data_stall !== 1'b0 || bus.id_valid !== 1'b1) begin
      errors++;
      $display("FAIL rd_zero_stall: data_stall=%b id_valid=%b, required 0 1", bus.data_stall, bus.id_valid);
    end
    tick();
    checks++;
    if (bus.stall_count !== 8'd0) begin
      errors++;
      $display("FAIL rd_zero_count: stall_count=%0d, required 0", bus.stall_count);
    end
    bus.ex_is_load = 1'b0;
  endtask

  task automatic test_flush_hazard();
    do_reset();
    capture(16'h5312, 8'h04);
    bus.ex_is_load = 1'b1;
    bus.ex_rd = 4'd1;
    bus.branch_flush = 1'b1;
    #1;
    checks++;
    if (bus.data_stall !== 1'b0 || bus.id_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_comb: data_stall=%b id_valid=%b, required 0 0", bus.data_stall, bus.id_valid);
    end
    tick();
    bus.branch_flush = 1'b0;
    bus.ex_is_load = 1'b0;
    #1;
    checks++;
    if (bus.id_valid !== 1'b0 || bus.id_opcode !== 4'h0 || bus.id_pc !== 8'h00 ||
        bus.flush_count !== 8'd1 || bus.stall_count !== 8'd0) begin
      errors++;
      $display("FAIL flush_bubble: v=%b op=%h pc=%h fcnt=%0d scnt=%0d, required 0 0 00 1 0",
               bus.id_valid, bus.id_opcode, bus.id_pc, bus.flush_count, bus.stall_count);
    end
  endtask

  task automatic test_flush_in_stall();
    do_reset();
    capture(16'h5312, 8'h04);
    bus.ex_is_load = 1'b1;
    bus.ex_rd = 4'd2;
    tick();
    bus.branch_flush = 1'b1;
    bus.IF_output = {16'h4321, 8'h08};
    #1;
    checks++;
    if (bus.data_stall !== 1'b0 || bus.id_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall_comb: data_stall=%b id_valid=%b, required 0 0", bus.data_stall, bus.id_valid);
    end
    tick();
    bus.branch_flush = 1'b0;
    #1;
    checks++;
    if (bus.id_valid !== 1'b0 || bus.id_opcode !== 4'h0 || bus.stall_count !== 8'd1 ||
        bus.flush_count !== 8'd1) begin
      errors++;
      $display("FAIL flush_stall_bubble: v=%b op=%h scnt=%0d fcnt=%0d, required 0 0 1 1",
               bus.id_valid, bus.id_opcode, bus.stall_count, bus.flush_count);
    end
    // Held instr 4321 has rs1=2: a stall now proves the bubble left the FSM in RUN.
    tick();
    checks++;
    if (bus.id_pc !== 8'h08 || bus.data_stall !== 1'b1) begin
      errors++;
      $display("FAIL flush_stall_run: pc=%h data_stall=%b, required 08 1", bus.id_pc, bus.data_stall);
    end
    bus.ex_is_load = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    capture(16'h5312, 8'h04);
    bus.ex_is_load = 1'b1;
    bus.ex_rd = 4'd1;
    bus.IF_output = {16'h7120, 8'h09};
    #1;
    checks++;
    if (bus.data_stall !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: data_stall=%b, required 1", bus.data_stall);
    end
    tick();
    bus.ex_rd = 4'd2;
    #1;
    checks++;
    if (bus.data_stall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap1: data_stall=%b, required 0", bus.data_stall);
    end
    tick();
    checks++;
    if (bus.data_stall !== 1'b1 || bus.id_pc !== 8'h09) begin
      errors++;
      $display("FAIL b2b_second: data_stall=%b pc=%h, required 1 09", bus.data_stall, bus.id_pc);
    end
    tick();
    checks++;
    if (bus.data_stall !== 1'b0 || bus.stall_count !== 8'd2) begin
      errors++;
      $display("FAIL b2b_gap2: data_stall=%b cnt=%0d, required 0 2", bus.data_stall, bus.stall_count);
    end
    bus.ex_is_load = 1'b0;
  endtask

  task automatic test_saturation();
    int consecutive = 0;
    logic prev = 1'b0;
    do_reset();
    capture(16'h5312, 8'h04);
    bus.ex_is_load = 1'b1;
    bus.ex_rd = 4'd1;
    // Each hazard costs two cycles (RUN stall, STALL recapture of the same instr).
    for (int i = 0; i < 600; i++) begin
      if (prev && bus.data_stall) consecutive++;
      prev = bus.data_stall;
      tick();
    end
    checks++;
    if (bus.stall_count !== 8'hFF) begin
      errors++;
      $display("FAIL sat_reach: stall_count=%h, required ff", bus.stall_count);
    end
    checks++;
    if (consecutive != 0) begin
      errors++;
      $display("FAIL sat_no_consecutive: consecutive stall cycles=%0d, required 0", consecutive);
    end
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (bus.stall_count !== 8'hFF) begin
      errors++;
      $display("FAIL sat_hold: stall_count=%h, required ff", bus.stall_count);
    end
    bus.ex_is_load = 1'b0;
  endtask

  task automatic test_reset_in_stall();
    do_reset();
    capture(16'h5312, 8'h04);
    bus.ex_is_load = 1'b1;
    bus.ex_rd = 4'd1;
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (bus.id_valid !== 1'b0 || bus.data_stall !== 1'b0 || bus.id_pc !== 8'h00 ||
        bus.id_opcode !== 4'h0 || bus.stall_count !== 8'h00 || bus.flush_count !== 8'h00) begin
      errors++;
      $display("FAIL rst_stall_vals: v=%b stall=%b pc=%h op=%h scnt=%h fcnt=%h, required 0 0 00 0 00 00",
               bus.id_valid, bus.data_stall, bus.id_pc, bus.id_opcode, bus.stall_count, bus.flush_count);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.data_stall !== 1'b1 || bus.id_pc !== 8'h04) begin
      errors++;
      $display("FAIL rst_stall_run: data_stall=%b pc=%h, required 1 04", bus.data_stall, bus.id_pc);
    end
    bus.ex_is_load = 1'b0;
  endtask

  initial begin
    bus.IF_output = 24'h0;
    bus.branch_flush = 1'b0;
    bus.ex_is_load = 1'b0;
    bus.ex_rd = 4'd0;
    test_reset();
    test_capture();
    test_stall();
    test_rd_zero();
    test_flush_hazard();
    test_flush_in_stall();
    test_back_to_back();
    test_saturation();
    test_reset_in_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_decode_latch.md
INSTRUCTION_DECODE_LATCH -- requirements
Module: instruction_decode_latch

Interface
REQ-001 Parameter LOAD_OPCODE, default 4'b1000: opcode value in instruction[15:12] identifying a load.
REQ-002 Parameter NOP_INSTR, default 16'h0000: instruction value inserted on reset and flush.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset; all state SHALL update only on the rising edge of clk.
REQ-004 Port clk, input, 1: system clock.
REQ-005 Port rst_n, input, 1: synchronous active-low reset.
REQ-006 Port IF_output, input, 24: fetch bundle; [7:0] PC, [23:8] instruction.
REQ-007 Port branch_flush, input, 1: taken branch resolved in EX; same cycle as the isBranch bit driven to fetch.
REQ-008 Port ex_is_load, input, 1: the instruction in ID/EX is a valid load.
REQ-009 Port ex_rd, input, 4: destination register of the ID/EX instruction.
REQ-010 Port data_stall, output, 1: combinational; freezes fetch PC and this latch.
REQ-011 Port id_valid, output, 1: combinational; latched instruction is issuable downstream this cycle.
REQ-012 Port id_pc, output, 8: latched PC.
REQ-013 Port id_opcode / id_rd / id_rs1 / id_rs2, output, 4 each: latched instruction bits [15:12] / [11:8] / [7:4] / [3:0].
REQ-014 Port id_imm, output, 8: latched instruction [7:0], zero-extended by consumers.
REQ-015 Port stall_count / flush_count, output, 8 each: saturating event counters.

Function
REQ-016 Internal state: held_valid, held_pc[7:0], held_instr[15:0], FSM state in {RUN, STALL}; field outputs SHALL decode held_instr directly.
REQ-017 hazard = held_valid & ex_is_load & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
REQ-018 data_stall SHALL be hazard & (state == RUN) & !branch_flush.
REQ-019 id_valid SHALL be held_valid & !data_stall & !branch_flush.
REQ-020 Priority at each edge: reset > branch_flush > data_stall > normal capture.
REQ-021 branch_flush=1: next cycle held_valid=0, held_instr=NOP_INSTR, held_pc=0, state=RUN, flush_count+1.
REQ-022 data_stall=1: held_* unchanged, state RUN->STALL, stall_count+1.
REQ-023 State STALL lasts exactly one cycle: data_stall forced 0, held_* captures IF_output with held_valid=1, state->RUN.
REQ-024 Normal capture (RUN, no stall, no flush): held_pc=IF_output[7:0], held_instr=IF_output[23:8], held_valid=1; latency one cycle from IF_output to id_* outputs.
REQ-025 Back-to-back load-use hazards SHALL each produce exactly one stall cycle; no two consecutive data_stall cycles.
REQ-026 Counters SHALL saturate at 8'hFF and never wrap.
REQ-027 ex_rd == 0 SHALL never cause a stall (register 0 hardwired zero).
REQ-028 Flush during STALL SHALL take priority: bubble loaded, state RUN, stall_count unchanged.

Reset
REQ-029 rst_n=0 at an edge: held_valid=0, held_pc=0, held_instr=NOP_INSTR, state=RUN, both counters 0; hence id_valid=0, data_stall=0, all fields 0.
REQ-030 Reset asserted mid-STALL or mid-flush SHALL override all other inputs that cycle.
REQ-031 First capture after rst_n rises SHALL take IF_output as presented (PC 0 expected).

Verification
REQ-032 Reset, then IF_output={16'h5012,8'h00} -> next cycle id_valid=1, id_pc=0, id_opcode=5, id_rd=0, id_rs1=1, id_rs2=2, id_imm=8'h12.
REQ-033 Held instr 16'h5312, ex_is_load=1, ex_rd=1 -> data_stall=1, id_valid=0 one cycle; held fields unchanged; next cycle data_stall=0, new instruction captured; stall_count=1.
REQ-034 Same hazard with ex_rd=0 -> data_stall=0, stall_count=0.
REQ-035 branch_flush=1 concurrent with hazard -> data_stall=0, id_valid=0; next cycle held_valid=0, id_opcode=0, flush_count=1.
REQ-036 Force 300 stall events -> stall_count=8'hFF, stays 8'hFF.
REQ-037 rst_n=0 during STALL -> next cycle all outputs at reset values, state RUN.
